// File: rtl/dpll_phase_detector.sv
// Phase detector for the DPLL core: measures the ref-to-feedback rising-edge separation in clock cycles
// and emits signed error samples, PFD-style up/dn levels and a lock indicator.
module dpll_phase_detector #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [ERR_W-1:0] err_out,
  output logic             err_valid,
  output logic             up,
  output logic             dn,
  output logic             overflow,
  output logic             locked
);

  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] MAX     = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0] NEG_MAX = ~MAX + ERR_W'(1);
  localparam logic [LCW-1:0]   LOCK_FULL = LCW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

  state_t state, state_next;
  logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
  logic ref_d, fb_d;
  logic rise_ref, rise_fb;
  logic [ERR_W-1:0] cnt, cnt_next, err_next, err_mag;
  logic strobe, ovf_next, in_tol;
  logic [LCW-1:0] lock_cnt, lock_cnt_next;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ref_sync  <= '0;
      fb_sync   <= '0;
      ref_d     <= 1'b0;
      fb_d      <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      err_out   <= '0;
      err_valid <= 1'b0;
      overflow  <= 1'b0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      ref_sync  <= {ref_sync[SYNC_STAGES-2:0], ref_in};
      fb_sync   <= {fb_sync[SYNC_STAGES-2:0], fb_in};
      ref_d     <= ref_sync[SYNC_STAGES-1];
      fb_d      <= fb_sync[SYNC_STAGES-1];
      state     <= state_next;
      cnt       <= cnt_next;
      err_out   <= err_next;
      err_valid <= strobe;
      overflow  <= ovf_next;
      lock_cnt  <= lock_cnt_next;
      locked    <= (lock_cnt_next == LOCK_FULL);
    end
  end

  assign rise_ref = ref_sync[SYNC_STAGES-1] & ~ref_d;
  assign rise_fb  = fb_sync[SYNC_STAGES-1] & ~fb_d;
  assign up = (state == REF_LEAD);
  assign dn = (state == FB_LEAD);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err_out;
    strobe     = 1'b0;
    ovf_next   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise_ref && rise_fb) begin
            err_next = '0;
            strobe   = 1'b1;
          end else if (rise_ref) begin
            state_next = REF_LEAD;
            cnt_next   = ERR_W'(1);
          end else if (rise_fb) begin
            state_next = FB_LEAD;
            cnt_next   = ERR_W'(1);
          end
        end
        REF_LEAD: begin
          if (rise_fb) begin
            err_next   = cnt;
            strobe     = 1'b1;
            state_next = rise_ref ? REF_LEAD : IDLE;
            cnt_next   = rise_ref ? ERR_W'(1) : '0;
          end else if (rise_ref) begin
            // Second reference edge before any feedback: cycle slip, restart from this edge.
            err_next = MAX;
            strobe   = 1'b1;
            ovf_next = 1'b1;
            cnt_next = ERR_W'(1);
          end else if (cnt == MAX) begin
            err_next   = MAX;
            strobe     = 1'b1;
            ovf_next   = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ERR_W'(1);
          end
        end
        FB_LEAD: begin
          if (rise_ref) begin
            err_next   = ~cnt + ERR_W'(1);
            strobe     = 1'b1;
            state_next = rise_fb ? FB_LEAD : IDLE;
            cnt_next   = rise_fb ? ERR_W'(1) : '0;
          end else if (rise_fb) begin
            err_next = NEG_MAX;
            strobe   = 1'b1;
            ovf_next = 1'b1;
            cnt_next = ERR_W'(1);
          end else if (cnt == MAX) begin
            err_next   = NEG_MAX;
            strobe     = 1'b1;
            ovf_next   = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ERR_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Lock qualification works on the registered sample; -2^(ERR_W-1) never occurs so negation is safe.
  always_comb begin
    err_mag       = err_out[ERR_W-1] ? (~err_out + ERR_W'(1)) : err_out;
    in_tol        = !overflow && (err_mag <= ERR_W'(LOCK_TOL));
    lock_cnt_next = lock_cnt;
    if (err_valid) begin
      if (!in_tol)
        lock_cnt_next = '0;
      else if (lock_cnt != LOCK_FULL)
        lock_cnt_next = lock_cnt + LCW'(1);
    end
  end

endmodule
